// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, divider/counter sizing and parity helpers.
// Used by uart_tx_frame (optional parity via UART_TX_PARITY_EN) and the receive path.
package uart_pkg;

  localparam int unsigned UART_CLKS_DEFAULT = 32'd100000000;
  localparam int unsigned UART_BAUD_DEFAULT = 32'd9600;
  localparam int unsigned UART_DATA_BITS    = 32'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int unsigned uart_div(input int unsigned clks, input int unsigned baud);
    return clks / baud;
  endfunction

  // Width of a counter spanning 0..div-1; never narrower than one bit.
  function automatic int unsigned uart_cnt_w(input int unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..DIV-1, wraps, and flags the last and second-to-last counts.
// i_clr holds the count at zero so a new frame always starts on a full bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 32'd10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_bit_pre
);

  localparam int unsigned   CW   = uart_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 32'd2);

  logic [CW-1:0] r_count;

  // Free-running bit-period counter, restarted by clear or by reaching the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_bit_end = (r_count == LAST);
  assign o_bit_pre = (r_count == PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// 8-bit UART transmitter, 8N1 by default, valid/ready byte input and registered line output.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS       = UART_CLKS_DEFAULT,
  parameter int unsigned BAUDRATE   = UART_BAUD_DEFAULT,
  parameter int unsigned STOP_BITS  = 32'd1,
  parameter int unsigned PARITY_ODD = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned DIV = uart_div(CLKS, BAUDRATE);

  // The done pulse is timed from the second-to-last count, so a bit needs at least two clocks.
  if ((DIV < 32'd2) || (STOP_BITS < 32'd1) || (STOP_BITS > 32'd2) || (PARITY_ODD > 32'd1)) begin : g_bad_cfg
    $error("uart_tx_frame: unsupported CLKS/BAUDRATE/STOP_BITS/PARITY_ODD combination");
  end

  uart_state_e r_state;
  uart_state_e w_state_next;

  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_tx;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;
  logic       w_tx_next;
  logic       w_accept;
  logic       w_bit_end;
  logic       w_bit_pre;
  logic       w_last_data;
  logic       w_last_stop;
  logic       w_timer_clr;

`ifdef UART_TX_PARITY_EN
  logic       r_parity;
`endif

  assign w_accept    = (r_state == ST_IDLE) && tx_valid;
  assign w_last_data = (r_bit_idx == 3'd7);
  assign w_last_stop = (STOP_BITS == 32'd1) || (r_stop_idx == 1'b1);
  assign w_timer_clr = (r_state == ST_IDLE);

  uart_bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_timer_clr),
    .o_bit_end(w_bit_end),
    .o_bit_pre(w_bit_pre)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: every non-idle transition happens on a bit boundary.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_START;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end && w_last_data) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end else begin
          w_state_next = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end && w_last_stop) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shift register: loads on accept, moves right after each completed data bit.
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept) begin
      w_shift_next = tx_data;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      w_shift_next = {1'b1, r_shift[7:1]};
    end else begin
      w_shift_next = r_shift;
    end
  end

  // Line level for the coming cycle, so tx itself is a plain flop.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_IDLE:   w_tx_next = 1'b1;
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_next = r_parity;
`endif
      ST_STOP:   w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase
  end

  // Data path registers and bit / stop-bit indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= 8'h00;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      if (w_accept) begin
        r_bit_idx  <= 3'd0;
        r_stop_idx <= 1'b0;
      end else begin
        if ((r_state == ST_DATA) && w_bit_end) begin
          r_bit_idx <= r_bit_idx + 3'd1;
        end
        if ((r_state == ST_STOP) && w_bit_end) begin
          r_stop_idx <= ~r_stop_idx;
        end
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at accept from the byte being latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= uart_parity(tx_data, PARITY_ODD[0]);
    end
  end
`endif

  // Registered outputs; done is raised one cycle early so it lands on the last STOP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx_next;
      r_ready <= (w_state_next == ST_IDLE);
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (r_state == ST_STOP) && w_last_stop && w_bit_pre;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: unit 0 is 8N1 even, unit 1 is two stop bits with odd parity.
// A frame-level model predicts every output each cycle; a line receiver decodes bytes.
module tb_uart_tx_frame;

  localparam int CLKS = 1000;
  localparam int BAUD = 100;
  localparam int DIV  = CLKS / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] v   = 2'b00;
  logic [7:0] d0  = 8'h00;
  logic [7:0] d1  = 8'h00;
  wire  [1:0] txo;
  wire  [1:0] rdy;
  wire  [1:0] bsy;
  wire  [1:0] dn;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  logic rst_q  = 1'b1;

  int         rem [2];
  logic [7:0] lat [2];
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  logic       rpar0 = 1'b0;
  logic       rpar1 = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS(CLKS), .BAUDRATE(BAUD), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v[0]), .tx_ready(rdy[0]),
    .tx(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

  uart_tx_frame #(.CLKS(CLKS), .BAUDRATE(BAUD), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v[1]), .tx_ready(rdy[1]),
    .tx(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

  function automatic int stop_of(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int u);
    return (1 + 8 + PAR + stop_of(u)) * DIV;
  endfunction

  // Line level of bit slot pos: start, data LSB first, optional parity, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int pos, input int u);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (PAR == 1 && pos == 9) return (^b) ^ (u == 1);
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a countdown of cycles started whenever the unit is idle and valid.
  always @(posedge clk) begin
    rst_q <= rst;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        rem[u] <= 0;
      end else if (rem[u] == 0 && v[u]) begin
        lat[u] <= (u == 0) ? d0 : d1;
        rem[u] <= frame_len(u);
      end else if (rem[u] > 0) begin
        rem[u] <= rem[u] - 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
          int   el;
          logic e_tx;
          el   = frame_len(u) - rem[u];
          e_tx = (rem[u] > 0) ? frame_bit(lat[u], el / DIV, u) : 1'b1;
          chk($sformatf("tx%0d", u),    int'(txo[u]), int'(e_tx));
          chk($sformatf("ready%0d", u), int'(rdy[u]), int'(rem[u] == 0));
          chk($sformatf("busy%0d", u),  int'(bsy[u]), int'(rem[u] > 0));
          chk($sformatf("done%0d", u),  int'(dn[u]),  int'(rem[u] == 1));
        end
      end
    end
  end

  // Mid-bit sampling receiver for one unit's line.
  task automatic rx_loop(input int u);
    logic prev, s;
    bit act;
    int c, n;
    logic [7:0] sh;
    prev = 1'b1; act = 1'b0; c = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      s = txo[u];
      if (rst_q === 1'b1 || !chk_en) begin
        act = 1'b0;
      end else if (!act) begin
        if (s === 1'b0 && prev === 1'b1) begin
          act = 1'b1;
          c = 1;
        end
      end else begin
        c++;
        if (c % DIV == DIV / 2) begin
          n = c / DIV;
          if (n >= 1 && n <= 8) sh[n-1] = s;
          else if (PAR == 1 && n == 9) begin
            if (u == 0) rpar0 = s; else rpar1 = s;
          end else if (n == 9 + PAR) begin
            if (u == 0) rxq0.push_back(sh); else rxq1.push_back(sh);
            act = 1'b0;
          end
        end
      end
      prev = s;
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  task automatic wait_ready(input int u);
    int w;
    w = 0;
    while (rdy[u] !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("ready_timeout", int'(w < 400), 1);
  endtask

  task automatic send(input int u, input logic [7:0] b, output int t_done, output int t_rdy);
    @(negedge clk);
    if (u == 0) d0 = b; else d1 = b;
    v[u] = 1'b1;
    wait_ready(u);
    @(posedge clk);
    @(negedge clk);
    v[u] = 1'b0;
    t_done = -1;
    t_rdy  = -1;
    for (int k = 1; k <= 400 && t_rdy < 0; k++) begin
      if (dn[u] === 1'b1 && t_done < 0) t_done = k;
      if (rdy[u] === 1'b1) t_rdy = k;
      if (t_rdy < 0) @(negedge clk);
    end
  endtask

  initial begin
    int td, tr, td1, td2, tb2, idle_n, ndone;

    chk("pin_len0", frame_len(0), 100 + 10 * PAR);
    chk("pin_len1", frame_len(1), 110 + 10 * PAR);
    chk("pin_bit_a3_2", int'(frame_bit(8'hA3, 2, 0)), 1);
    chk("pin_bit_a3_3", int'(frame_bit(8'hA3, 3, 0)), 0);

    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(txo[0]), 1);
      chk("rst_ready", int'(rdy[0]), 1);
      chk("rst_busy", int'(bsy[0]), 0);
      chk("rst_done", int'(dn[0]), 0);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(bsy[0] | bsy[1]), 0);
    chk("idle_tx", int'(txo[0] & txo[1]), 1);

    // Single byte
    rxq0.delete();
    send(0, 8'h55, td, tr);
    chk("single_done_cycle", td, 100 + 10 * PAR);
    chk("single_ready_cycle", tr, 101 + 10 * PAR);
    chk("single_rx_count", rxq0.size(), 1);
    if (rxq0.size() > 0) chk("single_rx_byte", int'(rxq0[0]), 8'h55);

    // Back-to-back with valid held and data switched after accept
    rxq0.delete();
    @(negedge clk);
    wait_ready(0);
    d0 = 8'hA3;
    v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d0 = 8'h0F;
    td1 = -1; td2 = -1; tb2 = -1; idle_n = 0;
    for (int k = 1; k <= 500 && td2 < 0; k++) begin
      if (td1 < 0) begin
        if (dn[0] === 1'b1) td1 = k;
      end else if (tb2 < 0) begin
        if (bsy[0] === 1'b1) begin
          tb2 = k;
          v[0] = 1'b0;
        end else begin
          idle_n++;
        end
      end else if (dn[0] === 1'b1) begin
        td2 = k;
      end
      @(negedge clk);
    end
    v[0] = 1'b0;
    chk("b2b_first_done", td1, 100 + 10 * PAR);
    chk("b2b_idle_cycles", idle_n, 1);
    chk("b2b_done_spacing", td2 - td1, 101 + 10 * PAR);
    chk("b2b_rx_count", rxq0.size(), 2);
    if (rxq0.size() > 1) begin
      chk("b2b_rx_first", int'(rxq0[0]), 8'hA3);
      chk("b2b_rx_second", int'(rxq0[1]), 8'h0F);
    end

    // Reset during data bit 4 of 0xFF
    wait_ready(0);
    rxq0.delete();
    @(negedge clk);
    d0 = 8'hFF;
    v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v[0] = 1'b0;
    ndone = 0;
    for (int k = 1; k < 55; k++) begin
      if (dn[0] === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_line_before", int'(txo[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", int'(txo[0]), 1);
    chk("abort_busy", int'(bsy[0]), 0);
    for (int k = 0; k < 120; k++) begin
      if (dn[0] === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_rx_empty", rxq0.size(), 0);
    send(0, 8'h3C, td, tr);
    chk("after_abort_done", td, 100 + 10 * PAR);
    chk("after_abort_rx_count", rxq0.size(), 1);
    if (rxq0.size() > 0) chk("after_abort_rx_byte", int'(rxq0[0]), 8'h3C);

    // Two stop bits
    rxq1.delete();
    send(1, 8'h00, td, tr);
    chk("stop2_done_cycle", td, 110 + 10 * PAR);
    chk("stop2_ready_cycle", tr, 111 + 10 * PAR);
    chk("stop2_rx_count", rxq1.size(), 1);
    if (rxq1.size() > 0) chk("stop2_rx_byte", int'(rxq1[0]), 8'h00);

`ifdef UART_TX_PARITY_EN
    send(0, 8'h07, td, tr);
    chk("par_even_bit", int'(rpar0), 1);
    chk("par_even_done", td, 110);
    send(1, 8'h07, td, tr);
    chk("par_odd_bit", int'(rpar1), 0);
`endif

    // Randomised traffic on both units, data churning every cycle, rare resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 3) != 0);
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      rst  = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    v   = 2'b00;
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("final_idle", int'(bsy[0] | bsy[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- 8-bit UART transmitter, 8N1 by default.
- Byte-parallel valid/ready input; serial line output drives PC_Uart_txd at top level.
- Transmit counterpart of the existing 9600-baud receive path on the 100 MHz board clock.
- Bit timing comes from an internal divider, so no external baud clock is needed.

Parameters:
- CLKS, 100000000: system clock frequency in Hz.
- BAUDRATE, 9600: line bit rate. DIV = CLKS/BAUDRATE, integer-truncated (default 10416); each bit lasts exactly DIV clk cycles.
- STOP_BITS, 1: stop bit count, 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- tx_data  in  8  byte to send, sampled on accept.
- tx_valid  in  1  byte offered.
- tx_ready  out  1  block can accept a byte this cycle.
- tx  out  1  serial line, idle high, registered.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0.
- Accept: occurs when tx_valid && tx_ready on a rising edge.
  - tx_data is latched into a shift register.
  - FSM moves IDLE->START.
  - tx goes 0 in the next cycle.
  - tx_ready is 1 only in IDLE. tx_valid outside IDLE is ignored and no byte is queued.
  - Changes to tx_data after accept have no effect.
- FSM states and line levels:
  - IDLE: tx=1.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - PARITY: only with the optional feature.
  - STOP: tx=1 for STOP_BITS*DIV cycles.
  - STOP->IDLE.
- Bit counter: counts 0..DIV-1 and restarts on every state or bit change. A 3-bit index selects the data bit. The shift register shifts right once per completed data bit.
- tx_busy is 1 in every state except IDLE.
- tx_done is asserted in the final clk cycle of STOP, i.e. the cycle before IDLE.
- Frame timing: from the accept edge to the next possible accept is (10 + STOP_BITS - 1)*DIV + 1 cycles, plus DIV with parity. For the default 8N1 this is 10*DIV+1 cycles.
- Back-to-back: a tx_valid held high is re-accepted on the first IDLE cycle. The single idle clk between frames is permitted.
- Reset mid-frame: the frame is aborted, tx=1 from the next cycle, and tx_done is not pulsed.
- Line glitches: tx is driven from a flop only; no combinational path exists from tx_data or tx_valid to tx.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP, DIV cycles long.
  - Even parity: bit = XOR of the 8 data bits.
  - Odd parity (PARITY_ODD=1): bit = inverted XOR.
  - Parity is computed at accept from the latched byte.
- Undefined: no PARITY state and no parity logic; PARITY_ODD is ignored.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Constant function computing DIV and counter width, ceil(log2(DIV)).
  - Default CLKS/BAUDRATE constants, shared with the receive path.
- Sub-module uart_bit_timer:
  - Counter with clear input and a one-cycle bit_end output at count DIV-1.
  - Reusable by a future receiver rewrite.

Test Plan (sim parameters CLKS=1000, BAUDRATE=100, so DIV=10):
- Reset check: hold rst 3 cycles -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; release, no activity without tx_valid.
- Single byte: send 0x55 -> tx = 0 (10 cycles), then 1,0,1,0,1,0,1,0 (10 cycles each), then 1 for 10 cycles; tx_done pulses at cycle 100 after accept; tx_ready returns at cycle 101.
- Back-to-back with hold: tx_valid held high with 0xA3, switched to 0x0F after accept -> first frame carries 0xA3 and is unaffected by the switch; the second frame starts exactly 1 idle cycle after tx_done; receiver model decodes 0xA3 then 0x0F.
- Reset mid-frame: assert rst during data bit 4 of 0xFF -> tx=1 the next cycle, no tx_done; a new byte 0x3C sends cleanly afterward.
- Parity (UART_TX_PARITY_EN): 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> 0; frame is 110 cycles.
- Two stop bits (STOP_BITS=2): 0x00 -> stop high for 20 cycles, tx_done at cycle 110.
